seven_seg_scan: RTL
===================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
- REQ-001: Parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range 2..2^20.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, synchronous, active-low.
- REQ-004: din  input  16  four BCD/hex nibbles; din[3:0] = digit 0 (rightmost), din[15:12] = digit 3.
- REQ-005: blank  input  4  per-digit blank mask, captured with din; 1 = digit dark.
- REQ-006: load  input  1  single-cycle strobe; captures din/blank into the pending buffer.
- REQ-007: digit  output  4  nibble for the currently lit digit; feeds the downstream seven-segment decoder.
- REQ-008: an  output  4  active-low anode enables, at most one bit low at any time.
- REQ-009: load_ack  output  1  one-cycle pulse when a pending value is committed to the display.

Function
- REQ-010: Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick asserts for exactly one cycle, when counter == REFRESH_DIV-1.
- REQ-011: Scan FSM SHALL have states D0, D1, D2, D3; each tick advances D0->D1->D2->D3->D0; no other transitions.
- REQ-012: In state Dk, digit SHALL equal active_val[4k+3:4k]; an SHALL be 1 with bit k cleared, unless active_blank[k] = 1, in which case an = 4'b1111.
- REQ-013: digit and an SHALL be decoded from registered state only (no path from din, blank or load).
- REQ-014: On load = 1, pending_val <= din, pending_blank <= blank, pending <= 1; a load while pending = 1 overwrites the buffer (last load wins).
- REQ-015: Commit SHALL occur only at frame end, i.e. tick while in D3: if pending = 1, active_val <= pending_val, active_blank <= pending_blank, pending <= 0, and load_ack = 1 on the following cycle.
- REQ-016: Load and commit in the same cycle: the old pending buffer is committed, the new din/blank are captured, pending remains 1, and load_ack still pulses.
- REQ-017: Frame end with pending = 0 SHALL leave active registers unchanged and SHALL NOT pulse load_ack.
- REQ-018: Commit latency SHALL be at most 4*REFRESH_DIV+1 cycles from load to load_ack.
- REQ-019: Display content SHALL NOT change within a frame (no tearing).

Reset
- REQ-020: While rst_n = 0 at a clock edge: counter = 0, state = D0, active_val = 16'h0000, active_blank = 4'b1111, pending = 0, pending buffer = 0, load_ack = 0.
- REQ-021: Consequently, one cycle after reset: an = 4'b1111, digit = 4'h0.
- REQ-022: Reset asserted mid-frame or with pending = 1 SHALL discard the pending value with no load_ack; load during reset is ignored.
- REQ-023: Scanning SHALL resume from D0 with counter 0 on the first edge after rst_n returns high.

Verification (bench REFRESH_DIV = 4)
- REQ-024: Reset then idle 20 cycles -> an = 4'b1111 throughout, digit = 0, load_ack never asserted.
- REQ-025: load with din = 16'h4321, blank = 0 -> load_ack within 17 cycles; thereafter an steps 1110,1101,1011,0111 every 4 cycles with digit 1,2,3,4.
- REQ-026: Two loads (16'hAAAA, then 16'h5555) in the same frame -> single load_ack; display shows 5 on all digits, never A.
- REQ-027: load coincident with D3 tick, din = 16'h00FF, previous pending 16'h1234 -> 1234 displayed next frame, second load_ack one frame later, then 00FF displayed.
- REQ-028: din = 16'h9876, blank = 4'b1010 -> an = 1111 in D1 and D3; an = 1110/1011 in D0/D2 with digit 6/8.
- REQ-029: Assert rst_n = 0 two cycles after a load -> no load_ack, an = 4'b1111, scan restarts at D0.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed display scanner with a double-buffered value.
// New values wait in a pending buffer and are committed only at frame end.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   din       four nibbles, din[3:0] is digit 0 (rightmost)
//   blank     per-digit dark mask, captured together with din
//   load      one-cycle strobe that captures din/blank into the pending buffer
//   digit     nibble of the digit currently lit
//   an        active-low anode enables, at most one bit low
//   load_ack  one-cycle pulse after a pending value is committed
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        load_ack
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {D0, D1, D2, D3} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_blank_q, act_blank_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_blank_q, pend_blank_d;
  logic          pend_q, pend_d;
  logic          ack_q, ack_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic          tick;
  logic          commit;

  assign tick   = (cnt_q == LAST);
  assign commit = tick && (state_q == D3) && pend_q;

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + ONE;
    state_d      = state_q;
    act_val_d    = act_val_q;
    act_blank_d  = act_blank_q;
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pend_d       = pend_q & ~commit;
    ack_d        = commit;

    if (tick) begin
      unique case (state_q)
        D0: state_d = D1;
        D1: state_d = D2;
        D2: state_d = D3;
        D3: state_d = D0;
      endcase
    end

    if (commit) begin
      act_val_d   = pend_val_q;
      act_blank_d = pend_blank_q;
    end

    // A load on the commit cycle refills the buffer just emptied.
    if (load) begin
      pend_val_d   = din;
      pend_blank_d = blank;
      pend_d       = 1'b1;
    end

    // Outputs are registered from next-state so they line up with state_q.
    digit_d = 4'h0;
    an_d    = 4'b1111;
    unique case (state_d)
      D0: begin
        digit_d = act_val_d[3:0];
        an_d    = act_blank_d[0] ? 4'b1111 : 4'b1110;
      end
      D1: begin
        digit_d = act_val_d[7:4];
        an_d    = act_blank_d[1] ? 4'b1111 : 4'b1101;
      end
      D2: begin
        digit_d = act_val_d[11:8];
        an_d    = act_blank_d[2] ? 4'b1111 : 4'b1011;
      end
      D3: begin
        digit_d = act_val_d[15:12];
        an_d    = act_blank_d[3] ? 4'b1111 : 4'b0111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= D0;
      cnt_q        <= '0;
      act_val_q    <= 16'h0000;
      act_blank_q  <= 4'b1111;
      pend_val_q   <= 16'h0000;
      pend_blank_q <= 4'b0000;
      pend_q       <= 1'b0;
      ack_q        <= 1'b0;
      digit_q      <= 4'h0;
      an_q         <= 4'b1111;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_val_q    <= act_val_d;
      act_blank_q  <= act_blank_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pend_q       <= pend_d;
      ack_q        <= ack_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
    end
  end

  assign digit    = digit_q;
  assign an       = an_q;
  assign load_ack = ack_q;

endmodule
